// File: rtl/seq_restoring_divider.sv
// Multi-cycle unsigned restoring divider: one quotient bit per clock, start/done handshake.
// Divide-by-zero short-circuits to a one-cycle result (quotient all ones, remainder = dividend).
module seq_restoring_divider #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] r_q, r_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] d_q;
  logic [CW-1:0]    cnt_q;

  logic [WIDTH:0]   r_shift;
  logic [WIDTH:0]   trial;

  // The partial remainder never reaches the divisor, so its top bit is
  // always zero after a restore and need not be stored.
  always_comb begin
    r_shift = {r_q, q_q[WIDTH-1]};
    trial   = r_shift - {1'b0, d_q};
    r_d     = r_shift[WIDTH-1:0];
    q_d     = {q_q[WIDTH-2:0], 1'b0};
    if (!trial[WIDTH]) begin
      r_d = trial[WIDTH-1:0];
      q_d = {q_q[WIDTH-2:0], 1'b1};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      r_q         <= '0;
      q_q         <= '0;
      d_q         <= '0;
      cnt_q       <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            busy <= 1'b1;
            if (divisor == '0) begin
              state_q     <= DONE;
              done        <= 1'b1;
              div_by_zero <= 1'b1;
              quotient    <= '1;
              remainder   <= dividend;
            end else begin
              state_q <= CALC;
              r_q     <= '0;
              q_q     <= dividend;
              d_q     <= divisor;
              cnt_q   <= '0;
            end
          end
        end
        CALC: begin
          r_q   <= r_d;
          q_q   <= q_d;
          cnt_q <= cnt_q + CW'(1);
          // The final iteration loads the results on the same edge.
          if (cnt_q == CNT_LAST) begin
            state_q     <= DONE;
            done        <= 1'b1;
            quotient    <= q_d;
            remainder   <= r_d;
            div_by_zero <= 1'b0;
          end
        end
        DONE: begin
          state_q <= IDLE;
          done    <= 1'b0;
          busy    <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          done    <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule
